aud_rec_i2s_multi: RTL

Parametrised successor to the lab-3 I2S recorder. It deserialises I2S audio clocked by the codec BCLK (i_clk) into DATA_W-bit words and writes them to SRAM through an address/data/strobe interface. Three capture modes are supported: left only, right only, and stereo interleaved. New over the previous generation: an explicit write strobe, a memory-full limit, abort of short slots, clean start on a channel edge, and a channel tag on each word.

---
 rtl/aud_rec_pkg.sv | 25 ++
 rtl/aud_i2s_deser.sv | 44 ++++
 rtl/aud_rec_i2s_multi.sv | 122 ++++++++++++
 3 files changed

// File: rtl/aud_rec_pkg.sv
// Shared types and helpers for the multi-mode I2S recorder.
// Holds the FSM state encoding, the capture-mode codes and the channel filter.
package aud_rec_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SHIFT = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LEFT   = 2'd0;
  localparam logic [1:0] MODE_RIGHT  = 2'd1;
  localparam logic [1:0] MODE_STEREO = 2'd2;

  // chan: 1 = left slot, 0 = right slot. The reserved mode code behaves as left.
  function automatic logic chan_selected(input logic [1:0] mode, input logic chan);
    case (mode)
      MODE_RIGHT:  return !chan;
      MODE_STEREO: return 1'b1;
      default:     return chan;
    endcase
  endfunction

endpackage

// File: rtl/aud_i2s_deser.sv
// Free-running I2S deserialiser: LRCK edge detect, per-slot bit counter and shift register.
// Any LRCK edge restarts the count, so a short slot never reaches word_valid.
module aud_i2s_deser #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic              lrc_q,
  output logic              lrc_edge,
  output logic              edge_chan,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;

  assign lrc_edge   = (i_lrc != lrc_q);
  assign edge_chan  = i_lrc;
  // The last bit of a slot is taken straight from the pin so the word is ready on that edge.
  assign word_valid = (bit_cnt == CNT_W'(DATA_W - 1));
  assign word       = {shift_q[DATA_W-2:0], i_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q   <= 1'b0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      lrc_q   <= i_lrc;
      shift_q <= {shift_q[DATA_W-2:0], i_data};
      if (lrc_edge) begin
        bit_cnt <= '0;
      end else if (bit_cnt != CNT_W'(DATA_W)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/aud_rec_i2s_multi.sv
// I2S recorder: captures left, right or interleaved stereo words and writes them to SRAM.
// The FSM owns addressing, the full limit, stop and pause; the deserialiser owns bit timing.
module aud_rec_i2s_multi
  import aud_rec_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr_en,
  output logic              o_chan,
  output logic              o_busy,
  output logic              o_full
);

  state_t            state;
  logic [1:0]        mode_q;
  logic              stop_pend;
  logic              pend_shift;
  logic              lrc_q;
  logic              lrc_edge;
  logic              edge_chan;
  logic              word_valid;
  logic [DATA_W-1:0] word;
  logic              edge_go;
  logic              stop_now;

  aud_i2s_deser #(.DATA_W(DATA_W)) u_deser (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_lrc      (i_lrc),
    .i_data     (i_data),
    .lrc_q      (lrc_q),
    .lrc_edge   (lrc_edge),
    .edge_chan  (edge_chan),
    .word_valid (word_valid),
    .word       (word)
  );

  assign edge_go  = lrc_edge && chan_selected(mode_q, edge_chan) && !i_pause;
  assign stop_now = i_stop || stop_pend;
  assign o_busy   = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      mode_q     <= MODE_LEFT;
      stop_pend  <= 1'b0;
      pend_shift <= 1'b0;
      o_address  <= '0;
      o_data     <= '0;
      o_wr_en    <= 1'b0;
      o_chan     <= 1'b0;
      o_full     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_address  <= '0;
            o_full     <= 1'b0;
            stop_pend  <= 1'b0;
            pend_shift <= 1'b0;
            mode_q     <= i_mode;
            state      <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (i_stop) begin
            state <= S_IDLE;
          end else if (edge_go) begin
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (i_stop) begin
            stop_pend <= 1'b1;
          end
          if (word_valid) begin
            // An edge on the completing bit opens the next slot; remember whether it qualifies.
            o_data     <= word;
            o_chan     <= lrc_q;
            o_wr_en    <= 1'b1;
            pend_shift <= edge_go;
            state      <= S_WRITE;
          end else if (lrc_edge) begin
            if (stop_now) begin
              state <= S_IDLE;
            end else if (!edge_go) begin
              state <= S_ARMED;
            end
          end
        end
        S_WRITE: begin
          o_wr_en   <= 1'b0;
          o_address <= o_address + ADDR_W'(1);
          if (o_address == MAX_ADDR) begin
            o_full <= 1'b1;
            state  <= S_IDLE;
          end else if (stop_now) begin
            state <= S_IDLE;
          end else if (lrc_edge) begin
            state <= edge_go ? S_SHIFT : S_ARMED;
          end else begin
            state <= pend_shift ? S_SHIFT : S_ARMED;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
